lsu_ld_router: RTL and testbench
================================

LSU_LD_ROUTER -- requirements
Module: lsu_ld_router

Interface
REQ-001 Parameter NUM_SRC, 3, number of load-data sources; index 0 = switches, 1 = output buffer (LEDs/7-seg/LCD), NUM_SRC-1 = memory.
REQ-002 Parameter DATA_W, 32, load data width; fixed at 32 for this generation.
REQ-003 Parameter ADDR_W, 16, LSU address width.
REQ-004 Parameter TIMEOUT, 15, maximum cycles in WAIT before an error response; legal range 1..255.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_ld_req  input  1  load request, sampled in IDLE only.
REQ-008 i_lsu_addr  input  ADDR_W  load byte address.
REQ-009 i_ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 i_src_data  input  NUM_SRC x DATA_W  word-aligned read data per source.
REQ-011 i_src_valid  input  NUM_SRC  per-source data-valid strobe.
REQ-012 o_ld_data  output  DATA_W  aligned, extended load result.
REQ-013 o_ld_valid  output  1  one-cycle response strobe.
REQ-014 o_ld_err  output  1  qualifies o_ld_valid: misaligned, illegal funct3 or timeout.
REQ-015 o_ld_busy  output  1  high whenever state is not IDLE; core stalls on it.

Function
REQ-016 Decode on i_lsu_addr[15:4]: 0x780 -> source 0; 0x700..0x703 -> source 1; all others -> source NUM_SRC-1.
REQ-017 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE with i_ld_req=1: latch source index, addr[1:0], funct3; clear timeout counter; go to WAIT, or directly to RESP with error if REQ-022 applies.
REQ-019 WAIT: i_src_valid of the latched source only is sampled; valids of other sources are ignored.
REQ-020 WAIT with selected valid=1: register extracted data into o_ld_data, go to RESP with o_ld_err=0.
REQ-021 WAIT with valid=0: counter increments; when counter reaches TIMEOUT, go to RESP with o_ld_err=1, o_ld_data=0.
REQ-022 Misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) or funct3 in {011,110,111}: no WAIT, RESP next cycle with o_ld_err=1, o_ld_data=0.
REQ-023 RESP: o_ld_valid=1 for exactly one cycle, then IDLE; o_ld_err meaningful only while o_ld_valid=1, otherwise 0.
REQ-024 Latency: request at cycle N, valid at N+k (k>=1) -> o_ld_valid at N+k+1; minimum 2 cycles; i_src_valid during the request cycle is ignored.
REQ-025 Extraction: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes word.
REQ-026 o_ld_data holds its last value between responses.
REQ-027 i_ld_req while o_ld_busy=1 is ignored; requester must hold it until busy drops.

Reset
REQ-028 Assertion of i_rst_n=0 at any time, including mid-WAIT, forces IDLE, counter 0, o_ld_data=0, o_ld_valid=0, o_ld_err=0, o_ld_busy=0; no response is emitted for the aborted load.
REQ-029 First request accepted on the first rising edge after deassertion.

Structure
REQ-030 Package lsu_pkg holds: funct3 load-type constants, region base constants (0x780, 0x700..0x703), source index constants, FSM state enum.
REQ-031 Sub-module lsu_ld_align: combinational byte/halfword select and extension (word, offset, funct3 -> result); instantiated once.

Verification
REQ-032 LW addr 0x7800, src0 data 0xDEADBEEF, valid at N+1 -> o_ld_valid at N+2, data 0xDEADBEEF, err 0.
REQ-033 LB addr 0x1003, mem word 0x80112233, valid at N+3 -> data 0xFFFFFF80 at N+4; repeat LBU -> 0x00000080.
REQ-034 LHU addr 0x7022, src1 word 0xABCD1234 -> 0x0000ABCD; LH same -> 0xFFFFABCD.
REQ-035 LW addr 0x1002 -> o_ld_valid and o_ld_err at N+1, data 0, no source wait.
REQ-036 LW addr 0x2000, mem valid never asserted, TIMEOUT=15 -> err response at N+16; src0 valid pulsed meanwhile has no effect.
REQ-037 Reset pulse at N+2 during WAIT -> no o_ld_valid, all outputs 0, next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU load-data router.
// Holds the funct3 load-type codes, the address-region bases used to pick a
// load-data source, the source indices, the router FSM state type and the
// latched request-control payload.
package lsu_pkg;

  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned REGION_W  = 12;
  localparam int unsigned REGION_LSB = 4;
  localparam int unsigned TMO_CNT_W = 8;

  // Load types
  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

  // Region bases, compared against address bits [15:4]
  localparam logic [REGION_W-1:0] REGION_SW     = 12'h780;
  localparam logic [REGION_W-1:0] REGION_BUF_LO = 12'h700;
  localparam logic [REGION_W-1:0] REGION_BUF_HI = 12'h703;

  // Fixed source indices; memory is always the last source
  localparam int unsigned SRC_SW  = 0;
  localparam int unsigned SRC_BUF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ld_state_e;

  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [FUNCT3_W-1:0] funct3;
  } ld_ctl_t;

  // True when a load must be answered with an error without touching a source
  function automatic logic ld_reject(input logic [FUNCT3_W-1:0] funct3,
                                     input logic [OFFSET_W-1:0] offset);
    logic rej;
    case (funct3)
      F3_LB, F3_LBU: rej = 1'b0;
      F3_LH, F3_LHU: rej = offset[0];
      F3_LW:         rej = (offset != 2'b00);
      default:       rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load-data alignment: picks the byte/halfword addressed by the low address
// bits out of a word-aligned read and sign- or zero-extends it.
// Ports:
//   word     - word-aligned source data
//   offset   - address bits [1:0]
//   funct3   - load type
//   result_c - aligned, extended result (combinational)
module lsu_ld_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   word,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [FUNCT3_W-1:0] funct3,
  output logic [DATA_W-1:0]   result_c
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  // Lane select
  always_comb begin
    byte_c = word[7:0];
    case (offset)
      2'd0:    byte_c = word[7:0];
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      default: byte_c = word[31:24];
    endcase
    half_c = offset[1] ? word[31:16] : word[15:0];
  end

  // Extension
  always_comb begin
    result_c = '0;
    case (funct3)
      F3_LB:   result_c = {{(DATA_W-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_LBU:  result_c = {{(DATA_W-BYTE_W){1'b0}}, byte_c};
      F3_LH:   result_c = {{(DATA_W-HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_LHU:  result_c = {{(DATA_W-HALF_W){1'b0}}, half_c};
      F3_LW:   result_c = word;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ld_router.sv
// LSU load router: decodes the load address to one of NUM_SRC data sources,
// waits for that source's valid strobe (with timeout), aligns/extends the
// returned word and emits a one-cycle response.
// Ports:
//   i_clk, i_rst_n      - clock, async active-low reset
//   i_ld_req            - load request (sampled in IDLE only)
//   i_lsu_addr          - load byte address
//   i_ld_funct3         - load type
//   i_src_data          - per-source word-aligned read data
//   i_src_valid         - per-source data-valid strobe
//   o_ld_data           - aligned load result, held between responses
//   o_ld_valid          - one-cycle response strobe
//   o_ld_err            - error qualifier for o_ld_valid
//   o_ld_busy           - high whenever not IDLE
module lsu_ld_router
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_ld_req,
  input  logic [ADDR_W-1:0]                i_lsu_addr,
  input  logic [FUNCT3_W-1:0]              i_ld_funct3,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   i_src_data,
  input  logic [NUM_SRC-1:0]               i_src_valid,
  output logic [DATA_W-1:0]                o_ld_data,
  output logic                             o_ld_valid,
  output logic                             o_ld_err,
  output logic                             o_ld_busy
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = TMO_CNT_W;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SRC_W-1:0]  src_q, src_d;
  ld_ctl_t           ctl_q, ctl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [REGION_W-1:0] region_c;
  logic [SRC_W-1:0]    src_sel_c;
  logic                sel_valid_c;
  logic [DATA_W-1:0]   align_c;
  logic                unused_addr_c;

  // Address bits [3:2] and anything above bit 15 play no part in routing
  assign unused_addr_c = ^i_lsu_addr;

  // Region decode
  assign region_c = i_lsu_addr[REGION_LSB +: REGION_W];

  always_comb begin
    src_sel_c = SRC_W'(NUM_SRC - 1);
    if (region_c == REGION_SW) begin
      src_sel_c = SRC_W'(SRC_SW);
    end else if ((region_c >= REGION_BUF_LO) && (region_c <= REGION_BUF_HI)) begin
      src_sel_c = SRC_W'(SRC_BUF);
    end
  end

  // Only the latched source's strobe and data are ever observed
  assign sel_valid_c = i_src_valid[src_q];

  lsu_ld_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .word     (i_src_data[src_q]),
    .offset   (ctl_q.offset),
    .funct3   (ctl_q.funct3),
    .result_c (align_c)
  );

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      ctl_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; response outputs are computed one cycle early so they are
  // registered coincident with entry into RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ctl_d   = ctl_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_ld_req) begin
          src_d        = src_sel_c;
          ctl_d.offset = i_lsu_addr[OFFSET_W-1:0];
          ctl_d.funct3 = i_ld_funct3;
          cnt_d        = '0;
          if (ld_reject(i_ld_funct3, i_lsu_addr[OFFSET_W-1:0])) begin
            state_d = ST_RESP;
            data_d  = '0;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A valid on the last permitted cycle still wins over the timeout
        if (sel_valid_c) begin
          state_d = ST_RESP;
          data_d  = align_c;
          valid_d = 1'b1;
        end else if (cnt_d == TMO_LIMIT) begin
          state_d = ST_RESP;
          data_d  = '0;
          valid_d = 1'b1;
          err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_ld_data  = data_q;
  assign o_ld_valid = valid_q;
  assign o_ld_err   = err_q;
  assign o_ld_busy  = busy_q;

endmodule

// File: tb/tb_lsu_ld_router.sv
// Self-checking bench for lsu_ld_router: directed vector table, reset-abort
// sequence and randomized loads checked against a behavioural model.
module tb_lsu_ld_router;

  localparam int NS  = 3;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 15;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   i_ld_req;
  logic [AW-1:0]          i_lsu_addr;
  logic [2:0]             i_ld_funct3;
  logic [NS-1:0][DW-1:0]  i_src_data;
  logic [NS-1:0]          i_src_valid;
  logic [DW-1:0]          o_ld_data;
  logic                   o_ld_valid;
  logic                   o_ld_err;
  logic                   o_ld_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ld_router #(
    .NUM_SRC (NS),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ld_req    (i_ld_req),
    .i_lsu_addr  (i_lsu_addr),
    .i_ld_funct3 (i_ld_funct3),
    .i_src_data  (i_src_data),
    .i_src_valid (i_src_valid),
    .o_ld_data   (o_ld_data),
    .o_ld_valid  (o_ld_valid),
    .o_ld_err    (o_ld_err),
    .o_ld_busy   (o_ld_busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  f3;
    logic [31:0] word;
    int          k;       // cycle offset of source valid, 0 = never
    bit          noise;   // random valids on other sources / request cycle
    bit          hold;    // keep i_ld_req high while busy
    logic [31:0] exp_d;
    bit          exp_e;
    int          exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Address map: 0x780x -> switches, 0x700x..0x703x -> output buffer, rest memory
  function automatic int src_of(input logic [15:0] a);
    int unsigned r;
    r = int'(a) / 16;
    if (r == 32'h780) return 0;
    if (r >= 32'h700 && r <= 32'h703) return 1;
    return NS - 1;
  endfunction

  // Reference: what a load should return and when
  task automatic model(input logic [15:0] a, input logic [2:0] f, input logic [31:0] w,
                       input int k, output logic [31:0] d, output bit e, output int lat);
    int unsigned off, b, h, wv;
    bit bad;
    off = int'(a) % 4;
    wv  = w;
    case (f)
      3'd0, 3'd4: bad = 1'b0;
      3'd1, 3'd5: bad = (off % 2) != 0;
      3'd2:       bad = (off != 0);
      default:    bad = 1'b1;
    endcase
    d = '0; e = 1'b1; lat = 1;
    if (!bad) begin
      if (k >= 1 && k <= TMO) begin
        e   = 1'b0;
        lat = k + 1;
        b   = (wv >> (8 * off)) % 256;
        h   = (wv >> (16 * (off / 2))) % 65536;
        case (f)
          3'd0:    d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd4:    d = b;
          3'd1:    d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
          3'd5:    d = h;
          default: d = wv;
        endcase
      end else begin
        lat = TMO + 1;
      end
    end
  endtask

  // Issue one load starting at a negedge in IDLE and check the whole response
  task automatic do_load(input string nm, input logic [15:0] addr, input logic [2:0] f3,
                         input logic [31:0] word, input int k, input bit noise, input bit hold,
                         input logic [31:0] exp_d, input bit exp_e, input int exp_lat);
    int          tgt;
    int          lat;
    bit          busy_ok;
    logic [31:0] got_d;
    logic        got_e;
    tgt = src_of(addr);
    lat = 0; busy_ok = 1'b1; got_d = '0; got_e = 1'b0;
    i_ld_req    = 1'b1;
    i_lsu_addr  = addr;
    i_ld_funct3 = f3;
    for (int s = 0; s < NS; s++) i_src_data[s] = (s == tgt) ? word : $urandom();
    i_src_valid = noise ? 3'($urandom()) : '0;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      @(negedge clk);
      if (o_ld_valid) begin
        lat   = t;
        got_d = o_ld_data;
        got_e = o_ld_err;
        if (!o_ld_busy) busy_ok = 1'b0;
      end else if (!o_ld_busy || o_ld_err) begin
        busy_ok = 1'b0;
      end
      i_ld_req    = (hold && lat == 0) ? 1'b1 : 1'b0;
      i_src_valid = '0;
      if (lat == 0) begin
        if (noise)
          for (int s = 0; s < NS; s++) if (s != tgt) i_src_valid[s] = 1'($urandom());
        if (t == k) i_src_valid[tgt] = 1'b1;
      end
    end
    check({nm, ".lat"},  32'(lat), 32'(exp_lat));
    check({nm, ".data"}, got_d, exp_d);
    check({nm, ".err"},  32'(got_e), 32'(exp_e));
    check({nm, ".busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({nm, ".pulse"}, {29'd0, o_ld_valid, o_ld_busy, o_ld_err}, 32'd0);
    check({nm, ".hold"},  o_ld_data, exp_d);
  endtask

  vec_t        vt[17];
  logic [15:0] ra;
  logic [2:0]  rf;
  logic [31:0] rw, rd;
  int          rk, rlat;
  bit          re, quiet;

  initial begin
    vt[0]  = '{16'h7800, 3'b010, 32'hDEADBEEF, 1,  0, 0, 32'hDEADBEEF, 0, 2};
    vt[1]  = '{16'h1003, 3'b000, 32'h80112233, 3,  0, 0, 32'hFFFFFF80, 0, 4};
    vt[2]  = '{16'h1003, 3'b100, 32'h80112233, 3,  0, 0, 32'h00000080, 0, 4};
    vt[3]  = '{16'h7022, 3'b101, 32'hABCD1234, 1,  0, 0, 32'h0000ABCD, 0, 2};
    vt[4]  = '{16'h7022, 3'b001, 32'hABCD1234, 1,  0, 0, 32'hFFFFABCD, 0, 2};
    vt[5]  = '{16'h1002, 3'b010, 32'h11111111, 1,  0, 0, 32'h00000000, 1, 1};
    vt[6]  = '{16'h2000, 3'b010, 32'h55555555, 0,  1, 0, 32'h00000000, 1, 16};
    vt[7]  = '{16'h1000, 3'b011, 32'h22222222, 1,  0, 0, 32'h00000000, 1, 1};
    vt[8]  = '{16'h1001, 3'b001, 32'h33333333, 1,  0, 0, 32'h00000000, 1, 1};
    vt[9]  = '{16'h7030, 3'b010, 32'hCAFEF00D, 15, 1, 1, 32'hCAFEF00D, 0, 16};
    vt[10] = '{16'h7801, 3'b000, 32'h00007F00, 2,  0, 0, 32'h0000007F, 0, 3};
    vt[11] = '{16'h1000, 3'b000, 32'h000000FF, 1,  1, 0, 32'hFFFFFFFF, 0, 2};
    vt[12] = '{16'h7040, 3'b101, 32'h80017FFE, 16, 1, 1, 32'h00000000, 1, 16};
    vt[13] = '{16'h7032, 3'b001, 32'h87654321, 5,  1, 1, 32'hFFFF8765, 0, 6};
    vt[14] = '{16'h1003, 3'b101, 32'h44444444, 1,  0, 0, 32'h00000000, 1, 1};
    vt[15] = '{16'h7800, 3'b110, 32'h66666666, 1,  0, 0, 32'h00000000, 1, 1};
    vt[16] = '{16'h7000, 3'b111, 32'h77777777, 1,  0, 0, 32'h00000000, 1, 1};

    rst_n = 1'b0; i_ld_req = 1'b0; i_lsu_addr = '0; i_ld_funct3 = '0;
    i_src_data = '0; i_src_valid = '0;
    repeat (3) @(negedge clk);
    check("reset.data", o_ld_data, 32'd0);
    check("reset.ctl", {29'd0, o_ld_valid, o_ld_err, o_ld_busy}, 32'd0);

    // First request is issued in the same cycle reset is released
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      do_load($sformatf("vec%0d", i), vt[i].addr, vt[i].f3, vt[i].word, vt[i].k,
              vt[i].noise, vt[i].hold, vt[i].exp_d, vt[i].exp_e, vt[i].exp_lat);

    // Reset in the middle of a WAIT aborts the load silently
    do_load("pre_rst", 16'h7800, 3'b010, 32'h12345678, 1, 0, 0, 32'h12345678, 0, 2);
    i_ld_req = 1'b1; i_lsu_addr = 16'h2000; i_ld_funct3 = 3'b010; i_src_valid = '0;
    @(negedge clk);
    i_ld_req = 1'b0;
    @(negedge clk);
    check("rst_mid.busy_before", 32'(o_ld_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.data", o_ld_data, 32'd0);
    check("rst_mid.ctl", {29'd0, o_ld_valid, o_ld_err, o_ld_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_src_valid = 3'b100;
    quiet = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (o_ld_valid || o_ld_busy || o_ld_err) quiet = 1'b0;
      i_src_valid = '0;
    end
    check("rst_mid.quiet", 32'(quiet), 32'd1);
    do_load("post_rst", 16'h1001, 3'b100, 32'hA5A55AA5, 2, 0, 0, 32'h0000005A, 0, 3);

    // Randomized loads against the model
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       ra = {12'h780, 4'($urandom())};
        1:       ra = {12'h700 + 12'($urandom_range(0, 3)), 4'($urandom())};
        default: ra = 16'($urandom());
      endcase
      rf = 3'($urandom());
      rw = $urandom();
      rk = $urandom_range(0, 18);
      model(ra, rf, rw, rk, rd, re, rlat);
      do_load($sformatf("rnd%0d", i), ra, rf, rw, rk, 1'($urandom()), 1'($urandom()),
              rd, re, rlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
